hex_display_pager: RTL and testbench
====================================

Name: hex_display_pager

Overview:
- Parametrised successor to the board-level hex debug display: pages through NUM_CHANNELS packed debug words (e.g. register-file taps) and drives DIGITS active-low seven-segment digits.
- Adds debounced next/prev page buttons with wrap-around, snapshot freeze and leading-zero blanking.
- Sits between the core's debug outputs and the HEX pins, in the top-level FPGA wrapper.

Parameters:
- NUM_CHANNELS, 8: number of selectable words; must be >= 2.
- DATA_W, 32: width of each word; must be a multiple of 4.
- DIGITS, DATA_W/4: number of driven digits; digit i shows nibble i.
- DEBOUNCE_CYCLES, 250000: clock cycles a button level must stay stable before it is accepted; must be >= 2.
- SCROLL_CYCLES, 50000000: auto-scroll period in cycles; used only with the optional feature.
- PAGE_W, $clog2(NUM_CHANNELS): width of the page index.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  NUM_CHANNELS*DATA_W  packed words; channel k is bits [k*DATA_W +: DATA_W].
- btn_next_n  in  1  raw, active-low, asynchronous button; advances the page.
- btn_prev_n  in  1  raw, active-low, asynchronous button; moves the page back.
- freeze  in  1  1 = hold the current snapshot.
- blank_lz  in  1  1 = blank leading zero digits.
- auto_scroll  in  1  auto-scroll enable; effective only with the optional feature.
- seg  out  DIGITS*7  per-digit active-low segments; digit i is bits [i*7 +: 7], where bit i*7+0 = a and bit i*7+6 = g.
- page  out  PAGE_W  current page index.
- page_changed  out  1  one-cycle pulse on every page update.

Behaviour:
- Reset is asynchronous and active-low. While reset = 0:
  - page = 0, page_changed = 0.
  - snapshot = 0, seg = all 1s (blank).
  - Synchroniser flops = 1, debounced states = 1 (released), debounce counters = 0, scroll counter = 0.
- Reset asserted mid-debounce or mid-scroll discards all progress.
- Button path, per button:
  - Two-flop synchroniser.
  - Debounce counter increments each cycle while the synced level differs from the stable level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the synced level and the counter clears.
  - A stable 1->0 transition produces a one-cycle press pulse. Release produces no pulse.
- Page update, evaluated at each clock edge:
  - next only: page = (page == NUM_CHANNELS-1) ? 0 : page+1.
  - prev only: page = (page == 0) ? NUM_CHANNELS-1 : page-1.
  - next and prev in the same cycle: no change, no pulse.
  - page_changed is registered; it is high for the one cycle following any page update.
- Snapshot:
  - When freeze = 0, the snapshot register loads data_in[page*DATA_W +: DATA_W] every edge.
  - When freeze = 1, the snapshot holds. Page changes while frozen still update page, but seg keeps showing the held snapshot until freeze drops.
- seg is registered from the snapshot:
  - Data latency is 2 edges: data_in sampled at edge N appears on seg after edge N+1.
  - After a page change, seg reflects the new channel 2 edges later.
- Nibble encoding (active-low, order g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110
- Leading-zero blanking:
  - When blank_lz = 1, every digit above the most significant nonzero nibble is all 1s.
  - Digit 0 is always displayed, so a value of 0 shows a single "0".
- If DIGITS < DATA_W/4, upper nibbles are not displayed. If DIGITS > DATA_W/4, the extra digits are blank.

Optional Feature:
- Macro: HEX_DISPLAY_PAGER_AUTO_SCROLL_EN.
- Defined:
  - Scroll counter runs while auto_scroll = 1. On reaching SCROLL_CYCLES-1 it performs a "next" page update and clears.
  - A button press pulse also clears the counter. The button action takes priority; auto and button updates never both occur in one cycle.
  - auto_scroll = 0 clears the counter.
- Not defined: no scroll counter is built, auto_scroll is ignored, and page changes only via the buttons.

Test Plan:
- Bench parameters: NUM_CHANNELS=4, DATA_W=16, DEBOUNCE_CYCLES=4, SCROLL_CYCLES=10.
1. Reset assert -> seg=all 1s, page=0. Release reset with channel 0=16'h12AF -> after 2 edges, digits 3..0 show 1,2,A,F (0001000 for A).
2. btn_next_n low for 3 cycles, then high -> no page change. Held low for 8 cycles -> exactly one page_changed pulse and page=1, 2+2+4 edges after the first low sample.
3. Starting at page=3, a next press -> page=0. From page=0, a prev press -> page=3.
4. freeze=1 with channel 1=16'h0005, then change the channel 1 input to 16'h0007 -> seg still shows 5. Release freeze -> 7 shown after 2 edges.
5. blank_lz=1 with value 16'h0005 -> digits 3..1 all 1s, digit 0 = 0010010. Value 16'h0000 -> only digit 0 shows 1000000.
6. With the macro defined and auto_scroll=1 -> page increments every 10 cycles. A prev press at count 7 -> page-1, counter cleared, next auto step 10 cycles later. Reset asserted mid-count -> page=0.

Source files
------------

// File: rtl/hex_display_pager.sv
// Purpose: pages through NUM_CHANNELS packed debug words onto DIGITS active-low seven-segment digits.
// Latency: data_in -> seg is 2 edges; button press -> page is 2 sync + DEBOUNCE_CYCLES + 2 edges.
// Backpressure: none; every input is sampled each cycle and the outputs are free-running.
//
// Ports:
//   clock, reset      system clock; asynchronous active-low reset
//   data_in           channel k at bits [k*DATA_W +: DATA_W]
//   btn_next_n/prev_n raw active-low asynchronous page buttons (synchronised + debounced here)
//   freeze            1 holds the displayed snapshot (page may still move)
//   blank_lz          1 blanks digits above the most significant nonzero nibble
//   auto_scroll       auto-advance enable (only with HEX_DISPLAY_PAGER_AUTO_SCROLL_EN)
//   seg               digit i at bits [i*7 +: 7], bit 0 = a .. bit 6 = g, active-low
//   page              current channel index
//   page_changed      one-cycle pulse following each page update
// Optional feature macro: HEX_DISPLAY_PAGER_AUTO_SCROLL_EN builds the auto-scroll counter.
module hex_display_pager #(
  parameter int NUM_CHANNELS    = 8,
  parameter int DATA_W          = 32,
  parameter int DIGITS          = DATA_W/4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCROLL_CYCLES   = 50000000,
  parameter int PAGE_W          = $clog2(NUM_CHANNELS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_CHANNELS*DATA_W-1:0] data_in,
  input  logic                           btn_next_n,
  input  logic                           btn_prev_n,
  input  logic                           freeze,
  input  logic                           blank_lz,
  input  logic                           auto_scroll,
  output logic [DIGITS*7-1:0]            seg,
  output logic [PAGE_W-1:0]              page,
  output logic                           page_changed
);

  localparam int NIB   = DATA_W/4;
  localparam int SHOWN = (DIGITS < NIB) ? DIGITS : NIB;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

  // Index 0 = next, index 1 = prev.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_prev_n, btn_next_n};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic            sync1;
    logic            sync2;
    logic            stable;
    logic            stable_d;
    logic            press_q;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync1    <= 1'b1;
        sync2    <= 1'b1;
        stable   <= 1'b1;
        stable_d <= 1'b1;
        press_q  <= 1'b0;
        db_cnt   <= '0;
      end else begin
        sync1    <= btn_raw[b];
        sync2    <= sync1;
        stable_d <= stable;
        // Only a falling stable level is a press; releases are silent.
        press_q  <= stable_d & ~stable;
        if (sync2 == stable) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES-1)) begin
          stable <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    assign press[b] = press_q;
  end

  logic auto_step;
  logic step_next;
  logic step_prev;

`ifdef HEX_DISPLAY_PAGER_AUTO_SCROLL_EN
  localparam int SC_W = $clog2(SCROLL_CYCLES);
  logic [SC_W-1:0] scroll_cnt;
  logic            scroll_wrap;

  assign scroll_wrap = (scroll_cnt == SC_W'(SCROLL_CYCLES-1));
  // Any button pulse wins over the auto step and restarts the period.
  assign auto_step   = auto_scroll && !(|press) && scroll_wrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scroll_cnt <= '0;
    end else if (!auto_scroll || (|press) || scroll_wrap) begin
      scroll_cnt <= '0;
    end else begin
      scroll_cnt <= scroll_cnt + 1'b1;
    end
  end
`else
  logic unused_auto;
  assign auto_step   = 1'b0;
  assign unused_auto = auto_scroll & (SCROLL_CYCLES > 0);
`endif

  // Simultaneous next and prev cancel out.
  assign step_next = (press[0] & ~press[1]) | auto_step;
  assign step_prev = press[1] & ~press[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      page         <= '0;
      page_changed <= 1'b0;
    end else begin
      page_changed <= step_next | step_prev;
      if (step_next) begin
        page <= (page == PAGE_W'(NUM_CHANNELS-1)) ? '0 : page + 1'b1;
      end else if (step_prev) begin
        page <= (page == '0) ? PAGE_W'(NUM_CHANNELS-1) : page - 1'b1;
      end
    end
  end

  logic [DATA_W-1:0] chan;
  logic [DATA_W-1:0] snap;

  always_comb begin
    chan = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (page == PAGE_W'(k)) chan = data_in[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap <= '0;
    end else if (!freeze) begin
      snap <= chan;
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b1000000;
      4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;
      4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;
      4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;
      4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0010000;
      4'hA: enc = 7'b0001000;
      4'hB: enc = 7'b0000011;
      4'hC: enc = 7'b1000110;
      4'hD: enc = 7'b0100001;
      4'hE: enc = 7'b0000110;
      default: enc = 7'b0001110;
    endcase
  endfunction

  int                   top_nz;
  logic [DIGITS*7-1:0]  seg_nxt;

  always_comb begin
    // Highest nonzero nibble over the whole word, so a nonzero undisplayed
    // upper nibble suppresses blanking of every shown digit.
    top_nz = 0;
    for (int i = 0; i < NIB; i++) begin
      if (snap[i*4 +: 4] != 4'h0) top_nz = i;
    end
    seg_nxt = '1;
    for (int i = 0; i < SHOWN; i++) begin
      if (!(blank_lz && (i > top_nz))) seg_nxt[i*7 +: 7] = enc(snap[i*4 +: 4]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg <= '1;
    end else begin
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_hex_display_pager.sv
module tb_hex_display_pager;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int DB = 4;
  localparam int SC = 10;
  localparam int PW = 2;
  localparam int DG = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NC*DW-1:0]  data_in;
  logic              btn_next_n = 1'b1;
  logic              btn_prev_n = 1'b1;
  logic              freeze = 1'b0;
  logic              blank_lz = 1'b0;
  logic              auto_scroll = 1'b0;
  logic [DG*7-1:0]   seg;
  logic [PW-1:0]     page;
  logic              page_changed;

  hex_display_pager #(
    .NUM_CHANNELS(NC), .DATA_W(DW), .DEBOUNCE_CYCLES(DB), .SCROLL_CYCLES(SC)
  ) dut (
    .clock(clock), .reset(reset), .data_in(data_in),
    .btn_next_n(btn_next_n), .btn_prev_n(btn_prev_n),
    .freeze(freeze), .blank_lz(blank_lz), .auto_scroll(auto_scroll),
    .seg(seg), .page(page), .page_changed(page_changed)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [6:0] rom [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: edge count, scheduled page events, snapshot and display.
  int          cyc = 0;
  int          m_page = 0;
  bit          m_chg = 1'b0;
  logic [15:0] m_snap = '0;
  logic [27:0] m_seg = '1;
  int          m_acnt = 0;
  int          ev_cyc[$];
  int          ev_dir[$];
  int          m_dir;
  bit          m_btn_ev;
  bit          m_fire;

  // Display of a 16-bit value: count significant hex digits arithmetically.
  function automatic logic [27:0] m_enc(input logic [15:0] v, input bit blz);
    int sig;
    int t;
    int idx;
    logic [27:0] r;
    sig = 1;
    t = int'(v) >> 4;
    while (t != 0) begin
      sig++;
      t = t >> 4;
    end
    for (int d = 0; d < 4; d++) begin
      idx = (int'(v) >> (4*d)) & 15;
      if (blz && d >= sig) r[d*7 +: 7] = 7'h7F;
      else r[d*7 +: 7] = rom[idx];
    end
    return r;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_page = 0; m_chg = 1'b0; m_snap = '0; m_seg = '1; m_acnt = 0;
      ev_cyc.delete(); ev_dir.delete();
    end else begin
      cyc++;
      m_btn_ev = 1'b0; m_dir = 0; m_fire = 1'b0;
      while (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
        m_btn_ev = 1'b1;
        m_dir += ev_dir[0];
        void'(ev_cyc.pop_front());
        void'(ev_dir.pop_front());
      end
      m_seg = m_enc(m_snap, blank_lz);
      if (!freeze) m_snap = data_in[m_page*DW +: DW];
      m_chg = 1'b0;
`ifdef HEX_DISPLAY_PAGER_AUTO_SCROLL_EN
      if (!auto_scroll || m_btn_ev) m_acnt = 0;
      else begin
        m_acnt++;
        if (m_acnt == SC) begin m_acnt = 0; m_fire = 1'b1; end
      end
`endif
      if (m_btn_ev && m_dir != 0) begin
        m_page = (m_page + m_dir + NC) % NC; m_chg = 1'b1;
      end else if (m_fire) begin
        m_page = (m_page + 1) % NC; m_chg = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("seg", 32'(seg), 32'(m_seg));
      check("page", 32'(page), 32'(m_page));
      check("page_changed", 32'(page_changed), 32'(m_chg));
    end
  end

  // All stimulus runs at 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // A held level of DB or more samples is accepted; the page moves 8 edges after drive.
  task automatic press(input bit nxt, input bit prv, input int hold);
    if (hold >= DB) begin
      ev_cyc.push_back(cyc + 8);
      ev_dir.push_back((nxt ? 1 : 0) - (prv ? 1 : 0));
    end
    btn_next_n = !nxt;
    btn_prev_n = !prv;
    step(hold);
    btn_next_n = 1'b1;
    btn_prev_n = 1'b1;
    step(12);
  endtask

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] BL = 7'b1111111;

  int p0;

  initial begin
    data_in = {16'hD9E8, 16'h0B00, 16'h3C40, 16'h12AF};
    #2 reset = 1'b0;
    #1 chk_en = 1'b1;
    step(3);
    check("rst_seg", 32'(seg), 32'h0FFFFFFF);
    check("rst_page", 32'(page), 0);
    reset = 1'b1;
    step(1);
    check("lat_edge1", 32'(seg), 32'({S0, S0, S0, S0}));
    step(1);
    check("lat_edge2_12AF", 32'(seg), 32'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}));

    press(1'b1, 1'b0, 3);
    check("short_press", 32'(page), 0);
    press(1'b1, 1'b0, 8);
    check("next_to_1", 32'(page), 1);
    check("show_3C40", 32'(seg), 32'({7'b0110000, 7'b1000110, 7'b0011001, S0}));

    press(1'b1, 1'b0, 4);
    press(1'b1, 1'b0, 4);
    check("next_to_3", 32'(page), 3);
    press(1'b1, 1'b0, 4);
    check("wrap_next", 32'(page), 0);
    press(1'b0, 1'b1, 4);
    check("wrap_prev", 32'(page), 3);
    press(1'b1, 1'b1, 6);
    check("both_pressed", 32'(page), 3);
    press(1'b0, 1'b1, 4);
    press(1'b0, 1'b1, 4);
    check("prev_to_1", 32'(page), 1);

    data_in[DW +: DW] = 16'h0005;
    step(3);
    freeze = 1'b1;
    step(1);
    data_in[DW +: DW] = 16'h0007;
    step(4);
    check("frozen_5", 32'(seg), 32'({S0, S0, S0, S5}));
    freeze = 1'b0;
    step(1);
    check("thaw_edge1", 32'(seg), 32'({S0, S0, S0, S5}));
    step(1);
    check("thaw_edge2", 32'(seg), 32'({S0, S0, S0, S7}));
    freeze = 1'b1;
    press(1'b1, 1'b0, 4);
    check("frozen_page", 32'(page), 2);
    check("frozen_seg", 32'(seg), 32'({S0, S0, S0, S7}));
    freeze = 1'b0;
    step(2);
    check("thaw_0B00", 32'(seg), 32'({S0, 7'b0000011, S0, S0}));
    press(1'b0, 1'b1, 4);

    blank_lz = 1'b1;
    data_in[DW +: DW] = 16'h0005;
    step(3);
    check("blank_5", 32'(seg), 32'({BL, BL, BL, S5}));
    data_in[DW +: DW] = 16'h0000;
    step(3);
    check("blank_0", 32'(seg), 32'({BL, BL, BL, S0}));
    data_in[DW +: DW] = 16'h0100;
    step(3);
    check("blank_0100", 32'(seg), 32'({BL, 7'b1111001, S0, S0}));
    blank_lz = 1'b0;
    step(2);

`ifdef HEX_DISPLAY_PAGER_AUTO_SCROLL_EN
    auto_scroll = 1'b1;
    step(10);
    check("auto_1st", 32'(page), 2);
    step(9);
    check("auto_hold", 32'(page), 2);
    step(1);
    check("auto_2nd", 32'(page), 3);
    for (int i = 0; i < 30 && m_acnt != 9; i++) step(1);
    check("auto_align", 32'(m_acnt), 9);
    p0 = m_page;
    press(1'b0, 1'b1, 4);
    check("prev_over_auto", 32'(page), 32'(p0));
    step(1);
    check("auto_restart_hold", 32'(page), 32'(p0));
    step(1);
    check("auto_restart", 32'(page), 32'((p0 + 1) % NC));
    step(5);
    reset = 1'b0;
    step(1);
    check("rst_mid_scroll", 32'(page), 0);
    reset = 1'b1;
    step(15);
    auto_scroll = 1'b0;
    step(2);
`else
    auto_scroll = 1'b1;
    step(25);
    check("auto_ignored", 32'(page), 1);
    auto_scroll = 1'b0;
`endif

    p0 = m_page;
    btn_next_n = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);
    btn_next_n = 1'b1;
    step(12);
    check("rst_mid_debounce", 32'(page), 0);

    step(3);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
